onewire_temp_scheduler: RTL and testbench
=========================================

Name: onewire_temp_scheduler

Overview:
Sequences a shared 1-wire byte engine to run complete DS18B20 temperature acquisitions: reset/presence, Skip ROM, Convert T, conversion wait, a second reset, Skip ROM, Read Scratchpad, a 9-byte read and a CRC check.
Acquisitions are triggered by an internal periodic timer or an on-demand request, and the two trigger sources are merged.
Validated results are published as raw and deci-degree temperature for the display/printf path.
The block sits between the top level and the 1-wire byte engine; the byte engine owns the inout pin.

Parameters:
PERIOD_CYC, 50_000_000, cycles between automatic acquisitions (1 s at 50 MHz); 0 disables the periodic timer.
CONV_CYC, 37_500_000, conversion wait after Convert T (750 ms).
TIMEOUT_CYC, 5_000_000, maximum cycles from command acceptance to rsp_valid (100 ms).

Ports:
clk_main  in  1  system clock, 50 MHz
reset  in  1  synchronous, active-high reset
start_req  in  1  one-cycle pulse requesting an acquisition
cmd_valid  out  1  command to the byte engine is valid
cmd_ready  in  1  byte engine accepts the command
cmd_op  out  2  0 = reset/presence, 1 = write byte, 2 = read byte
cmd_wdata  out  8  byte to write (LSB first on the wire)
rsp_valid  in  1  one-cycle pulse: command finished
rsp_data  in  8  byte read (valid with rsp_valid for read commands)
rsp_presence  in  1  presence detected (valid with rsp_valid for reset commands)
busy  out  1  acquisition in progress
temp_raw  out  16  last good scratchpad bytes {byte1, byte0}
temp_dc  out  16  signed, units of 0.1 °C
temp_valid  out  1  one-cycle pulse when new good data is published
err_code  out  2  0 = ok, 1 = no presence, 2 = CRC fail, 3 = timeout
sample_cnt  out  16  count of good acquisitions, wraps at 0xFFFF -> 0

Behaviour:
- Reset (synchronous, active-high, takes effect from any state): state = IDLE; cmd_valid = 0; busy = 0; temp_raw = 0; temp_dc = 0; temp_valid = 0; err_code = 0; sample_cnt = 0; pending = 0; period timer = 0.
  - Mid-acquisition reset abandons the sequence. No output updates on that edge beyond the reset values.
- Command handshake:
  - cmd_valid, cmd_op and cmd_wdata are held stable until the cycle with cmd_valid & cmd_ready; cmd_valid drops the next cycle.
  - Exactly one command outstanding. The block waits for rsp_valid before issuing the next command.
  - rsp_valid with no outstanding command is ignored.
- Triggers:
  - Period timer counts every cycle while PERIOD_CYC != 0. On reaching PERIOD_CYC-1 it wraps to 0 and raises a trigger.
  - start_req or a timer trigger sets pending.
  - Triggers arriving while busy merge into the single pending bit (one-deep, no queue).
  - In IDLE with pending: clear pending, set busy, enter RST1 on the next cycle.
- States (each command state issues one command and waits for rsp_valid):
  - IDLE -> RST1 (op 0) -> SKIP1 (0xCC) -> CONV (0x44) -> WAIT_CONV -> RST2 (op 0) -> SKIP2 (0xCC) -> RDSCR (0xBE) -> READ -> CHECK -> IDLE.
  - WAIT_CONV: counts exactly CONV_CYC cycles with no bus activity.
  - READ: 9 read-byte commands; bytes are stored at indices 0..8. CRC8 accumulates on each rsp_valid.
  - RST1/RST2 with rsp_presence = 0: err_code = 1, go to IDLE.
  - CHECK:
    - Running CRC == 0 (Dallas CRC8, polynomial 0x31 reflected 0x8C, init 0x00, over all 9 bytes): temp_raw = {b1, b0}; temp_dc = (signed(temp_raw) * 10) >>> 4 (floor, 20-bit intermediate, truncated to 16); temp_valid pulses one cycle; err_code = 0; sample_cnt += 1.
    - Otherwise err_code = 2; temp_raw and temp_dc are kept.
  - Any command waiting longer than TIMEOUT_CYC after acceptance, or unaccepted for TIMEOUT_CYC: err_code = 3, cmd_valid = 0, go to IDLE.
  - busy deasserts on the cycle the state returns to IDLE.
- err_code holds until the next acquisition completes.
- Latency from trigger to IDLE with data is 1 cycle plus command time plus CONV_CYC.

Decomposition:
- Shared package onewire_pkg holds:
  - op encodings: OP_RESET = 0, OP_WRITE = 1, OP_READ = 2
  - ROM/function codes: CMD_SKIP_ROM = 0xCC, CMD_CONVERT_T = 0x44, CMD_READ_SCR = 0xBE
  - CRC polynomial 0x8C, scratchpad length 9
  - err_code constants
- One sub-module: onewire_crc8. Byte-serial, single cycle per byte, with clear and enable inputs and an 8-bit crc output.

Test Plan:
- Engine model returns presence = 1 and scratchpad 50 05 4B 46 7F FF 0C 10 1C after start_req -> command sequence reset, CC, 44, (wait CONV_CYC), reset, CC, BE, 9 reads; temp_raw = 0x0550; temp_dc = 850; temp_valid pulses once; sample_cnt = 1; err_code = 0.
- Scratchpad with b0 = 0x5E, b1 = 0xFF and a model-computed valid CRC -> temp_dc = -102 (0xFF9A).
- Same as the first scenario but byte 8 = 0x1D -> err_code = 2; temp_raw unchanged from the prior good value; no temp_valid; sample_cnt unchanged.
- rsp_presence = 0 on RST1 -> err_code = 1; no write commands issued; busy low within 2 cycles of rsp_valid.
- Model withholds rsp_valid on CONV -> err_code = 3 exactly TIMEOUT_CYC cycles after acceptance; then a start_req and a normal model response -> successful acquisition.
- PERIOD_CYC = 1000 with 3 start_req pulses during a busy acquisition -> exactly one extra acquisition follows; reset asserted mid-READ -> all outputs return to reset values and cmd_valid = 0 the next cycle.

Source files
------------

// File: rtl/onewire_pkg.sv
// rtl/onewire_pkg.sv - shared encodings and helpers for the 1-wire temperature scheduler
//
// Contents:
//   OP_*      byte-engine command opcodes
//   CMD_*     DS18B20 ROM/function command bytes
//   CRC_POLY  Dallas CRC8 polynomial (reflected form)
//   SCR_LEN   scratchpad length in bytes
//   ERR_*     err_code values
//   state_t   acquisition sequencer states
//   raw_to_dc raw 1/16 degC reading -> signed 0.1 degC
package onewire_pkg;

   localparam logic [1:0] OP_RESET = 2'd0;
   localparam logic [1:0] OP_WRITE = 2'd1;
   localparam logic [1:0] OP_READ  = 2'd2;

   localparam logic [7:0] CMD_SKIP_ROM  = 8'hCC;
   localparam logic [7:0] CMD_CONVERT_T = 8'h44;
   localparam logic [7:0] CMD_READ_SCR  = 8'hBE;

   localparam logic [7:0] CRC_POLY = 8'h8C;
   localparam int         SCR_LEN  = 9;

   localparam logic [1:0] ERR_OK          = 2'd0;
   localparam logic [1:0] ERR_NO_PRESENCE = 2'd1;
   localparam logic [1:0] ERR_CRC         = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT     = 2'd3;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_RST1,
      ST_SKIP1,
      ST_CONV,
      ST_WAIT_CONV,
      ST_RST2,
      ST_SKIP2,
      ST_RDSCR,
      ST_READ,
      ST_CHECK
   } state_t;

   // Raw reading is in 1/16 degC. Multiply by 10 in a 20-bit signed product,
   // then an arithmetic shift floors toward minus infinity before truncation.
   function automatic logic [15:0] raw_to_dc(input logic [15:0] raw);
      logic signed [19:0] prod;
      prod = $signed({{4{raw[15]}}, raw}) * 20'sd10;
      return 16'(prod >>> 4);
   endfunction

endpackage

// File: rtl/onewire_crc8.sv
// rtl/onewire_crc8.sv - byte-serial Dallas CRC8, one byte per cycle
//
// Ports:
//   clk    in   clock
//   reset  in   synchronous active-high reset, crc -> 0
//   clear  in   synchronous clear, crc -> 0 (wins over en)
//   en     in   fold data into the running crc this cycle
//   data   in   8-bit byte, processed LSB first
//   crc    out  running crc; 0 after a full block with its trailing crc byte
module onewire_crc8
   import onewire_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       clear,
   input  logic       en,
   input  logic [7:0] data,
   output logic [7:0] crc
);

   logic [7:0] crc_next;

   // Bitwise LFSR unrolled across the byte, matching the wire bit order.
   always_comb begin
      crc_next = crc;
      for (int i = 0; i < 8; i++) begin
         if (crc_next[0] ^ data[i]) begin
            crc_next = (crc_next >> 1) ^ CRC_POLY;
         end else begin
            crc_next = crc_next >> 1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         crc <= '0;
      end else if (en) begin
         crc <= crc_next;
      end
   end

endmodule

// File: rtl/onewire_temp_scheduler.sv
// rtl/onewire_temp_scheduler.sv - sequences DS18B20 acquisitions over a shared 1-wire byte engine
//
// Ports:
//   clk_main      in   system clock
//   reset         in   synchronous active-high reset
//   start_req     in   one-cycle acquisition request
//   cmd_valid     out  command to byte engine valid
//   cmd_ready     in   byte engine accepts command
//   cmd_op        out  0 reset/presence, 1 write byte, 2 read byte
//   cmd_wdata     out  byte to write
//   rsp_valid     in   one-cycle command completion
//   rsp_data      in   byte read
//   rsp_presence  in   presence detected (reset commands)
//   busy          out  acquisition in progress
//   temp_raw      out  last good {byte1, byte0}
//   temp_dc       out  signed temperature in 0.1 degC
//   temp_valid    out  one-cycle pulse on new good data
//   err_code      out  0 ok, 1 no presence, 2 CRC fail, 3 timeout
//   sample_cnt    out  count of good acquisitions (wrapping)
module onewire_temp_scheduler
   import onewire_pkg::*;
#(
   parameter int unsigned PERIOD_CYC  = 50_000_000,
   parameter int unsigned CONV_CYC    = 37_500_000,
   parameter int unsigned TIMEOUT_CYC = 5_000_000
) (
   input  logic        clk_main,
   input  logic        reset,
   input  logic        start_req,
   output logic        cmd_valid,
   input  logic        cmd_ready,
   output logic [1:0]  cmd_op,
   output logic [7:0]  cmd_wdata,
   input  logic        rsp_valid,
   input  logic [7:0]  rsp_data,
   input  logic        rsp_presence,
   output logic        busy,
   output logic [15:0] temp_raw,
   output logic [15:0] temp_dc,
   output logic        temp_valid,
   output logic [1:0]  err_code,
   output logic [15:0] sample_cnt
);

   localparam logic [31:0] PERIOD_LAST = 32'(PERIOD_CYC) - 32'd1;
   localparam logic [31:0] TMO_LAST    = 32'(TIMEOUT_CYC) - 32'd1;
   localparam logic [3:0]  LAST_BYTE   = 4'(SCR_LEN - 1);

   state_t      state;
   state_t      state_next;

   logic        issued;      // command accepted, response outstanding
   logic [31:0] cyc_cnt;     // shared timeout / conversion wait counter
   logic [31:0] period_cnt;
   logic        pending;
   logic [3:0]  byte_idx;
   logic [7:0]  b0;
   logic [7:0]  b1;
   logic [7:0]  crc;

   logic        is_cmd_state;
   logic        accept;
   logic        rsp_ok;
   logic        timed_out;
   logic        conv_done;
   logic        period_tick;
   logic        presence_fail;
   logic        crc_clear;
   logic        crc_en;
   logic [15:0] new_raw;

   // ---------------------------------------------------------------------
   // Handshake qualifiers
   // ---------------------------------------------------------------------
   assign is_cmd_state = (state == ST_RST1)  || (state == ST_SKIP1) ||
                         (state == ST_CONV)  || (state == ST_RST2)  ||
                         (state == ST_SKIP2) || (state == ST_RDSCR) ||
                         (state == ST_READ);

   assign accept = cmd_valid && cmd_ready;

   // Responses only count once our command has been accepted; strays are dropped.
   assign rsp_ok = is_cmd_state && issued && rsp_valid;

   // One budget for both halves of a command: waiting for acceptance and
   // waiting for the response. The counter restarts on acceptance.
   assign timed_out = is_cmd_state && (cyc_cnt == TMO_LAST) &&
                      !(issued ? rsp_valid : cmd_ready);

   assign conv_done = (cyc_cnt + 32'd1) >= 32'(CONV_CYC);

   assign period_tick = (PERIOD_CYC != 0) && (period_cnt == PERIOD_LAST);

   assign presence_fail = ((state == ST_RST1) || (state == ST_RST2)) &&
                          rsp_ok && !rsp_presence;

   assign crc_clear = (state == ST_RDSCR) && rsp_ok;
   assign crc_en    = (state == ST_READ) && rsp_ok;

   assign new_raw = {b1, b0};

   onewire_crc8 u_crc (
      .clk   (clk_main),
      .reset (reset),
      .clear (crc_clear),
      .en    (crc_en),
      .data  (rsp_data),
      .crc   (crc)
   );

   // ---------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk_main) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // ---------------------------------------------------------------------
   // FSM: next state
   // ---------------------------------------------------------------------
   always_comb begin
      state_next = state;
      if (timed_out) begin
         state_next = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:      if (pending) state_next = ST_RST1;
            ST_RST1:      if (rsp_ok) state_next = rsp_presence ? ST_SKIP1 : ST_IDLE;
            ST_SKIP1:     if (rsp_ok) state_next = ST_CONV;
            ST_CONV:      if (rsp_ok) state_next = ST_WAIT_CONV;
            ST_WAIT_CONV: if (conv_done) state_next = ST_RST2;
            ST_RST2:      if (rsp_ok) state_next = rsp_presence ? ST_SKIP2 : ST_IDLE;
            ST_SKIP2:     if (rsp_ok) state_next = ST_RDSCR;
            ST_RDSCR:     if (rsp_ok) state_next = ST_READ;
            ST_READ:      if (rsp_ok && (byte_idx == LAST_BYTE)) state_next = ST_CHECK;
            ST_CHECK:     state_next = ST_IDLE;
            default:      state_next = ST_IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // FSM: outputs
   // ---------------------------------------------------------------------
   always_comb begin
      cmd_valid = is_cmd_state && !issued;
      busy      = (state != ST_IDLE);
      cmd_op    = OP_RESET;
      cmd_wdata = 8'h00;
      case (state)
         ST_SKIP1, ST_SKIP2: begin
            cmd_op    = OP_WRITE;
            cmd_wdata = CMD_SKIP_ROM;
         end
         ST_CONV: begin
            cmd_op    = OP_WRITE;
            cmd_wdata = CMD_CONVERT_T;
         end
         ST_RDSCR: begin
            cmd_op    = OP_WRITE;
            cmd_wdata = CMD_READ_SCR;
         end
         ST_READ: begin
            cmd_op    = OP_READ;
         end
         default: begin
            cmd_op    = OP_RESET;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Command bookkeeping and counters
   // ---------------------------------------------------------------------
   always_ff @(posedge clk_main) begin
      if (reset) begin
         issued   <= 1'b0;
         cyc_cnt  <= '0;
         byte_idx <= '0;
         b0       <= '0;
         b1       <= '0;
      end else begin
         // A response either moves the FSM on or, in READ, re-arms the
         // next read; in both cases the next command starts unissued.
         if ((state_next != state) || rsp_ok) begin
            issued <= 1'b0;
         end else if (accept) begin
            issued <= 1'b1;
         end

         if ((state_next != state) || accept || rsp_ok) begin
            cyc_cnt <= '0;
         end else begin
            cyc_cnt <= cyc_cnt + 32'd1;
         end

         if (crc_clear) begin
            byte_idx <= '0;
         end else if (crc_en) begin
            byte_idx <= byte_idx + 4'd1;
         end

         // Only the temperature bytes are kept; the rest feed the CRC.
         if (crc_en && (byte_idx == 4'd0)) b0 <= rsp_data;
         if (crc_en && (byte_idx == 4'd1)) b1 <= rsp_data;
      end
   end

   // ---------------------------------------------------------------------
   // Trigger merge: timer and on-demand requests share one pending bit
   // ---------------------------------------------------------------------
   always_ff @(posedge clk_main) begin
      if (reset) begin
         period_cnt <= '0;
         pending    <= 1'b0;
      end else begin
         if (PERIOD_CYC != 0) begin
            period_cnt <= period_tick ? 32'd0 : period_cnt + 32'd1;
         end

         // A fresh trigger in the consuming cycle is a new request, so set wins.
         if (start_req || period_tick) begin
            pending <= 1'b1;
         end else if (state == ST_IDLE) begin
            pending <= 1'b0;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Result publication
   // ---------------------------------------------------------------------
   always_ff @(posedge clk_main) begin
      if (reset) begin
         temp_raw   <= '0;
         temp_dc    <= '0;
         temp_valid <= 1'b0;
         err_code   <= ERR_OK;
         sample_cnt <= '0;
      end else begin
         temp_valid <= 1'b0;
         if (timed_out) begin
            err_code <= ERR_TIMEOUT;
         end else if (presence_fail) begin
            err_code <= ERR_NO_PRESENCE;
         end else if (state == ST_CHECK) begin
            if (crc == 8'h00) begin
               temp_raw   <= new_raw;
               temp_dc    <= raw_to_dc(new_raw);
               temp_valid <= 1'b1;
               err_code   <= ERR_OK;
               sample_cnt <= sample_cnt + 16'd1;
            end else begin
               err_code <= ERR_CRC;
            end
         end
      end
   end

endmodule

// File: tb/tb_onewire_temp_scheduler.sv
// tb/tb_onewire_temp_scheduler.sv - self-checking bench for onewire_temp_scheduler
module tb_onewire_temp_scheduler;

   localparam int PERIOD = 1000;
   localparam int CONV   = 20;
   localparam int TMO    = 100;

   logic        clk_main = 1'b0;
   logic        reset = 1'b1;
   logic        start_req = 1'b0;
   logic        cmd_valid;
   logic        cmd_ready = 1'b0;
   logic [1:0]  cmd_op;
   logic [7:0]  cmd_wdata;
   logic        rsp_valid = 1'b0;
   logic [7:0]  rsp_data = 8'h00;
   logic        rsp_presence = 1'b0;
   logic        busy;
   logic [15:0] temp_raw;
   logic [15:0] temp_dc;
   logic        temp_valid;
   logic [1:0]  err_code;
   logic [15:0] sample_cnt;

   onewire_temp_scheduler #(
      .PERIOD_CYC  (PERIOD),
      .CONV_CYC    (CONV),
      .TIMEOUT_CYC (TMO)
   ) dut (
      .clk_main     (clk_main),
      .reset        (reset),
      .start_req    (start_req),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_op       (cmd_op),
      .cmd_wdata    (cmd_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_data     (rsp_data),
      .rsp_presence (rsp_presence),
      .busy         (busy),
      .temp_raw     (temp_raw),
      .temp_dc      (temp_dc),
      .temp_valid   (temp_valid),
      .err_code     (err_code),
      .sample_cnt   (sample_cnt)
   );

   always #5 clk_main = ~clk_main;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;

   initial forever begin
      @(posedge clk_main);
      cyc++;
   end

   // Scoreboards: expected commands {op, wdata} and expected results {raw, dc}
   logic [9:0]  exp_cmd [$];
   logic [31:0] exp_res [$];

   // Engine model state
   logic [7:0] scr [0:8];
   logic       m_presence = 1'b1;
   bit         withhold_conv = 1'b0;
   int         m_phase = 0;
   int         m_dly = 0;
   int         m_lat = 0;
   int         m_reads = 0;
   int         n_tv = 0;
   int         t_rsp = 0;
   int         t_acc = 0;
   bit         seen_flag = 1'b0;
   bit         after_conv = 1'b0;
   logic [1:0] m_op = 2'd0;
   logic [7:0] m_wd = 8'd0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk_main);
      #2;
   endtask

   // Byte-engine model: runs on the falling edge, away from DUT sampling.
   initial forever begin
      logic [9:0] e;
      @(negedge clk_main);
      rsp_valid = 1'b0;
      if (temp_valid) n_tv++;
      if (reset) begin
         m_phase   = 0;
         cmd_ready = 1'b0;
         seen_flag = 1'b0;
      end else begin
         case (m_phase)
            0: if (cmd_valid) begin
                  if (!seen_flag) begin
                     seen_flag = 1'b1;
                     if (after_conv) begin
                        check("conv_gap", cyc - t_rsp, CONV + 1);
                        after_conv = 1'b0;
                     end
                  end
                  if (m_dly == 0) begin
                     cmd_ready = 1'b1;
                     m_op      = cmd_op;
                     m_wd      = cmd_wdata;
                     m_phase   = 1;
                  end else begin
                     m_dly--;
                  end
               end
            1: begin
                  cmd_ready = 1'b0;
                  seen_flag = 1'b0;
                  t_acc     = cyc;
                  check("cmd_drop", cmd_valid, 0);
                  check("cmd_expected", exp_cmd.size() != 0, 1);
                  if (exp_cmd.size() != 0) begin
                     e = exp_cmd.pop_front();
                     check("cmd_op", m_op, e[9:8]);
                     if (e[9:8] == 2'd1) check("cmd_wdata", m_wd, e[7:0]);
                  end
                  if (withhold_conv && m_op == 2'd1 && m_wd == 8'h44) begin
                     m_phase = 3;
                  end else begin
                     m_lat   = $urandom_range(0, 2);
                     m_phase = 2;
                  end
                  m_dly = $urandom_range(0, 2);
               end
            2: if (m_lat == 0) begin
                  rsp_valid    = 1'b1;
                  t_rsp        = cyc;
                  rsp_data     = 8'h00;
                  rsp_presence = 1'b0;
                  if (m_op == 2'd0) begin
                     rsp_presence = m_presence;
                     m_reads      = 0;
                  end else if (m_op == 2'd2) begin
                     if (m_reads < 9) rsp_data = scr[m_reads];
                     m_reads++;
                  end
                  after_conv = (m_op == 2'd1) && (m_wd == 8'h44);
                  m_phase    = 0;
               end else begin
                  m_lat--;
               end
            default: ;
         endcase
      end
   end

   function automatic logic [7:0] crc_calc(input int n);
      logic [7:0] c;
      logic [7:0] b;
      c = 8'h00;
      for (int i = 0; i < n; i++) begin
         b = scr[i];
         for (int k = 0; k < 8; k++) begin
            if (c[0] ^ b[k]) c = (c >> 1) ^ 8'h8C;
            else             c = c >> 1;
         end
      end
      return c;
   endfunction

   function automatic bit cond(input int which);
      case (which)
         0:       return temp_valid === 1'b1;
         1:       return busy === 1'b0;
         2:       return err_code === 2'd3;
         3:       return busy === 1'b1;
         default: return m_reads >= 3;
      endcase
   endfunction

   task automatic wait_sig(input int which, input int lim, input string tag);
      int n;
      n = 0;
      while (!cond(which) && n < lim) begin
         tick(1);
         n++;
      end
      check({tag, "_wait"}, cond(which), 1);
   endtask

   task automatic load_good();
      scr = '{8'h50, 8'h05, 8'h4B, 8'h46, 8'h7F, 8'hFF, 8'h0C, 8'h10, 8'h1C};
   endtask

   task automatic push_acq(input bit good, input logic [15:0] raw, input logic [15:0] dc);
      exp_cmd.push_back({2'd0, 8'h00});
      exp_cmd.push_back({2'd1, 8'hCC});
      exp_cmd.push_back({2'd1, 8'h44});
      exp_cmd.push_back({2'd0, 8'h00});
      exp_cmd.push_back({2'd1, 8'hCC});
      exp_cmd.push_back({2'd1, 8'hBE});
      for (int i = 0; i < 9; i++) exp_cmd.push_back({2'd2, 8'h00});
      if (good) exp_res.push_back({raw, dc});
   endtask

   task automatic got_result(input string tag);
      logic [31:0] e;
      check({tag, "_have_exp"}, exp_res.size() != 0, 1);
      if (exp_res.size() != 0) begin
         e = exp_res.pop_front();
         check({tag, "_raw"}, temp_raw, e[31:16]);
         check({tag, "_dc"}, temp_dc, e[15:0]);
      end
   endtask

   task automatic pulse_start();
      start_req = 1'b1;
      tick(1);
      start_req = 1'b0;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
   endtask

   initial begin
      int tv0;
      int t_rel;
      load_good();
      tick(3);
      reset = 1'b0;

      check("rst_busy", busy, 0);
      check("rst_cmd_valid", cmd_valid, 0);
      check("rst_temp_raw", temp_raw, 0);
      check("rst_temp_dc", temp_dc, 0);
      check("rst_temp_valid", temp_valid, 0);
      check("rst_err", err_code, 0);
      check("rst_sample_cnt", sample_cnt, 0);

      // Good acquisition with the reference scratchpad
      push_acq(1'b1, 16'h0550, 16'd850);
      pulse_start();
      wait_sig(0, 600, "s1_tv");
      got_result("s1");
      check("s1_sample_cnt", sample_cnt, 1);
      check("s1_err", err_code, 0);
      check("s1_busy", busy, 0);
      tick(1);
      check("s1_tv_pulse", temp_valid, 0);

      // CRC failure keeps the previous result
      scr[8] = 8'h1D;
      tv0 = n_tv;
      push_acq(1'b0, 16'h0, 16'h0);
      pulse_start();
      wait_sig(3, 20, "s3_busy");
      wait_sig(1, 600, "s3_idle");
      tick(2);
      check("s3_err", err_code, 2);
      check("s3_raw_kept", temp_raw, 16'h0550);
      check("s3_dc_kept", temp_dc, 16'd850);
      check("s3_sample_cnt", sample_cnt, 1);
      check("s3_no_tv", n_tv, tv0);
      check("s3_cmds_done", exp_cmd.size(), 0);

      // Negative temperature with a freshly computed CRC
      load_good();
      scr[0] = 8'h5E;
      scr[1] = 8'hFF;
      scr[8] = crc_calc(8);
      push_acq(1'b1, 16'hFF5E, 16'hFF9A);
      pulse_start();
      wait_sig(0, 600, "s2_tv");
      got_result("s2");
      check("s2_sample_cnt", sample_cnt, 2);
      check("s2_err", err_code, 0);

      // No presence on the first reset
      load_good();
      pulse_reset();
      m_presence = 1'b0;
      exp_cmd.push_back({2'd0, 8'h00});
      pulse_start();
      wait_sig(3, 20, "np_busy");
      wait_sig(1, 100, "np_idle");
      check("np_busy_latency", (cyc - t_rsp) <= 2, 1);
      check("np_err", err_code, 1);
      tick(10);
      check("np_cmds_done", exp_cmd.size(), 0);
      check("np_cmd_valid", cmd_valid, 0);

      // Withheld Convert T response times out, then a normal acquisition
      m_presence = 1'b1;
      withhold_conv = 1'b1;
      push_acq(1'b0, 16'h0, 16'h0);
      pulse_start();
      wait_sig(2, 400, "to_err");
      check("to_latency", cyc - t_acc, TMO);
      check("to_busy", busy, 0);
      check("to_cmd_valid", cmd_valid, 0);
      withhold_conv = 1'b0;
      m_phase = 0;
      exp_cmd.delete();
      push_acq(1'b1, 16'h0550, 16'd850);
      pulse_start();
      wait_sig(0, 600, "to_rec_tv");
      got_result("to_rec");
      check("to_rec_err", err_code, 0);
      check("to_rec_sample_cnt", sample_cnt, 1);

      // Three requests while busy merge into one extra run; then the timer fires
      pulse_reset();
      t_rel = cyc;
      push_acq(1'b1, 16'h0550, 16'd850);
      push_acq(1'b1, 16'h0550, 16'd850);
      pulse_start();
      wait_sig(3, 20, "mg_busy");
      for (int i = 0; i < 3; i++) begin
         tick(4);
         pulse_start();
      end
      wait_sig(0, 600, "mg_tv1");
      got_result("mg1");
      tick(1);
      wait_sig(0, 600, "mg_tv2");
      got_result("mg2");
      while (cyc < t_rel + PERIOD - 10) tick(1);
      check("mg_idle_before_period", busy, 0);
      check("mg_sample_cnt", sample_cnt, 2);
      check("mg_cmds_done", exp_cmd.size(), 0);
      push_acq(1'b1, 16'h0550, 16'd850);
      wait_sig(0, 600, "tm_tv");
      got_result("tm");
      check("tm_after_period", (cyc - t_rel) >= PERIOD, 1);
      check("tm_sample_cnt", sample_cnt, 3);

      // Reset in the middle of the scratchpad read
      m_reads = 0;
      push_acq(1'b0, 16'h0, 16'h0);
      pulse_start();
      wait_sig(4, 600, "mr_reads");
      pulse_reset();
      exp_cmd.delete();
      check("mr_cmd_valid", cmd_valid, 0);
      check("mr_busy", busy, 0);
      check("mr_temp_raw", temp_raw, 0);
      check("mr_temp_dc", temp_dc, 0);
      check("mr_temp_valid", temp_valid, 0);
      check("mr_err", err_code, 0);
      check("mr_sample_cnt", sample_cnt, 0);
      tick(20);
      check("mr_stays_idle", busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
